// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between the instruction fetch
// port (read-only) and the data port (read/write). The data port normally wins;
// a saturating starvation counter lets a waiting fetch through after MAX_WAIT
// lost arbitrations. Writes finish in the grant cycle. Reads hold the RAM
// address for RAM_LAT cycles, then pulse the owner's valid for one cycle.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RAM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_i_req,
  input  logic [ADDR_W-1:0] i_i_addr,
  output logic [DATA_W-1:0] o_i_rdata,
  output logic              o_i_valid,
  output logic              o_i_stall,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_valid,
  output logic              o_d_stall,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  // The +2 keeps both counters at least one bit wide, even for MAX_WAIT=0.
  localparam int LAT_W  = $clog2(RAM_LAT + 2);
  localparam int WCNT_W = $clog2(MAX_WAIT + 2);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RAM_LAT);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WAIT);

  typedef enum logic {S_IDLE, S_RD_WAIT} state_t;

  state_t              state_q;
  logic                owner_q;     // 1 = data port owns the read in flight
  logic [LAT_W-1:0]    lat_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                i_valid_q;
  logic                d_valid_q;

  logic is_idle, i_elig, d_elig, grant_i, grant_d, d_wr;

  // A port is eligible when it requests and is not already being answered.
  // The data port wins unless fetch has been passed over MAX_WAIT times.
  always_comb begin
    is_idle = (state_q == S_IDLE);
    i_elig  = i_i_req & ~i_valid_q;
    d_elig  = i_d_req & ~d_valid_q;
    grant_i = is_idle & i_elig & (~d_elig | (wcnt_q == WCNT_MAX));
    grant_d = is_idle & d_elig & ~grant_i;
    d_wr    = grant_d & i_d_we;
  end

  // RAM address: the winner's address in the grant cycle, otherwise the latched one.
  always_comb begin
    o_ram_addr = addr_q;
    if (grant_i)      o_ram_addr = i_i_addr;
    else if (grant_d) o_ram_addr = i_d_addr;
  end

  assign o_ram_wdata = i_d_wdata;
  assign o_ram_we    = d_wr & ~i_rst;
  assign o_i_stall   = i_i_req & ~i_valid_q;
  assign o_d_stall   = i_d_req & ~d_valid_q & ~d_wr;
  assign o_i_rdata   = i_rdata_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_i_valid   = i_valid_q;
  assign o_d_valid   = d_valid_q;

  // Arbitration FSM: start reads, count down the RAM latency, capture the
  // read data and track fetch starvation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      lat_q     <= '0;
      wcnt_q    <= '0;
      addr_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_i)
            wcnt_q <= '0;
          else if (grant_d && i_elig && (wcnt_q != WCNT_MAX))
            wcnt_q <= wcnt_q + 1'b1;
          if (grant_i || (grant_d && !i_d_we)) begin
            addr_q  <= grant_i ? i_i_addr : i_d_addr;
            owner_q <= grant_d;
            lat_q   <= LAT_LOAD;
            state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          lat_q <= lat_q - 1'b1;
          if (lat_q == LAT_W'(1)) begin
            state_q <= S_IDLE;
            // Data is always captured; valid only if the requester is still asking.
            if (owner_q) begin
              d_rdata_q <= i_ram_rdata;
              d_valid_q <= i_d_req;
            end else begin
              i_rdata_q <= i_ram_rdata;
              i_valid_q <= i_i_req;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
